mem_modport: RTL and testbench

// - Small synchronous single-port register-file memory, 4 words x 8 bits by default.
// - Driven and sampled through the shared memory interface (addr, wr_en, rd_en, wr_data, rd_data).
// - Serves as the leaf storage block for memory-model verification.
// - Registered read: data appears one clock after the read request.

---
 rtl/mem_modport_pkg.sv | 9 +
 rtl/mem_modport_array.sv | 33 +++
 rtl/mem_modport.sv | 54 +++++
 tb/tb_mem_modport.sv | 96 +++++++++
 4 files changed

// File: rtl/mem_modport_pkg.sv
// Shared memory types and default geometry for the register-file memory.
package mem_pkg;
   localparam int MEM_ADDR_W = 2;
   localparam int MEM_DATA_W = 8;
   localparam int MEM_DEPTH  = 2 ** MEM_ADDR_W;

   typedef logic [MEM_DATA_W-1:0] mem_word_t;
   typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
endpackage : mem_pkg

// File: rtl/mem_modport_array.sv
// DEPTH x DATA_WIDTH storage: synchronous write/clear port and an
// unregistered read tap that always shows the pre-edge contents, which
// gives read-before-write once the tap is sampled on the same edge.
module mem_array
   import mem_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = MEM_ADDR_W,
   parameter int                    DATA_WIDTH  = MEM_DATA_W,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  clr_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rword_o
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

   // Clear every word, otherwise store the write word at addr.
   always_ff @(posedge clk) begin
      if (clr_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VALUE;
      end else if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // Current (old) word at addr; the caller registers it.
   assign rword_o = mem_q[addr_i];
endmodule : mem_array

// File: rtl/mem_modport.sv
// Single-port register-file memory with a 1-cycle registered read.
// Reset wins over any access in the same cycle; rd_data holds when idle.
module mem_modport
   import mem_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = MEM_ADDR_W,
   parameter int                    DATA_WIDTH  = MEM_DATA_W,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data
);
   logic                  clr;
   logic                  we;
   logic [DATA_WIDTH-1:0] rword;
   logic [DATA_WIDTH-1:0] rd_data_d;
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Reset is active-low; it masks both enables.
   assign clr = ~rst;
   assign we  = rst & wr_en;

   mem_array #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUE)
   ) u_array (
      .clk     (clk),
      .clr_i   (clr),
      .we_i    (we),
      .addr_i  (addr),
      .wdata_i (wr_data),
      .rword_o (rword)
   );

   // Load the old word on a read, otherwise hold the last read value.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) rd_data_d = rword;
   end

   // Read data register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst) rd_data_q <= RESET_VALUE;
      else      rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;
endmodule : mem_modport

// File: tb/tb_mem_modport.sv
// Directed bench for mem_modport: inputs change #1 after posedge,
// rd_data is checked #1 after the following posedge.
module tb_mem_modport;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] addr;
   logic       wr_en;
   logic       rd_en;
   logic [7:0] wr_data;
   logic [7:0] rd_data;

   int n_pass  = 0;
   int n_total = 0;

   mem_modport dut (
      .clk     (clk),
      .rst     (rst),
      .addr    (addr),
      .wr_en   (wr_en),
      .rd_en   (rd_en),
      .wr_data (wr_data),
      .rd_data (rd_data)
   );

   always #5 clk = ~clk;

   // Apply one cycle of inputs, then advance to #1 after the sampling edge.
   task automatic cyc(input logic r, input logic w, input logic rd,
                      input logic [1:0] a, input logic [7:0] d);
      rst = r; wr_en = w; rd_en = rd; addr = a; wr_data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] exp);
      n_total++;
      assert (rd_data === exp) n_pass++;
      else $error("FAIL %s: rd_data=%h expected=%h", tag, rd_data, exp);
   endtask

   initial begin
      logic [7:0] wv [4];
      wv[0] = 8'h11; wv[1] = 8'h22; wv[2] = 8'h33; wv[3] = 8'h44;
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;

      // Reset for two clocks.
      cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
      chk("reset_rd", 8'h00);

      // Fresh memory reads zero everywhere.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 2'(i), 8'h00);
         chk($sformatf("rst_word%0d", i), 8'h00);
      end

      // Write then read back all words.
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 2'(i), wv[i]);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 2'(i), 8'h00);
         chk($sformatf("rdback%0d", i), wv[i]);
      end

      // Overwrite addr 2 twice; neighbours untouched.
      cyc(1'b1, 1'b1, 1'b0, 2'd2, 8'hA5);
      cyc(1'b1, 1'b1, 1'b0, 2'd2, 8'h5A);
      cyc(1'b1, 1'b0, 1'b1, 2'd2, 8'h00); chk("ovw_a2", 8'h5A);
      cyc(1'b1, 1'b0, 1'b1, 2'd0, 8'h00); chk("ovw_a0", 8'h11);
      cyc(1'b1, 1'b0, 1'b1, 2'd1, 8'h00); chk("ovw_a1", 8'h22);
      cyc(1'b1, 1'b0, 1'b1, 2'd3, 8'h00); chk("ovw_a3", 8'h44);

      // Same-cycle read and write at addr 1: old word returned.
      cyc(1'b1, 1'b1, 1'b1, 2'd1, 8'hFF); chk("rbw_old", 8'h22);
      cyc(1'b1, 1'b0, 1'b1, 2'd1, 8'h00); chk("rbw_new", 8'hFF);

      // Hold: rd_en low for 5 clocks while addr 3 is rewritten.
      cyc(1'b1, 1'b0, 1'b1, 2'd3, 8'h00); chk("hold_pre", 8'h44);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 2'd3, 8'h00);
         chk($sformatf("hold%0d", i), 8'h44);
      end
      cyc(1'b1, 1'b0, 1'b1, 2'd3, 8'h00); chk("hold_post", 8'h00);

      // Idle cycle with an address change keeps rd_data.
      cyc(1'b1, 1'b0, 1'b0, 2'd1, 8'h00); chk("idle_hold", 8'h00);
      cyc(1'b1, 1'b0, 1'b1, 2'd0, 8'h00); chk("pre_rst_a0", 8'h11);

      // Reset in the same cycle as a write to addr 0.
      cyc(1'b0, 1'b1, 1'b1, 2'd0, 8'h77); chk("midrst_rd", 8'h00);
      cyc(1'b1, 1'b0, 1'b1, 2'd0, 8'h00); chk("midrst_a0", 8'h00);
      cyc(1'b1, 1'b0, 1'b1, 2'd1, 8'h00); chk("midrst_a1", 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule : tb_mem_modport
